// File: rtl/complex_mac_pipe.sv
// Four-stage pipelined complex multiply / conjugate-multiply / dot-product unit.
// Full-precision signed arithmetic; one sample per cycle, no backpressure.
module complex_mac_pipe #(
  parameter  int WIDTH   = 32,
  parameter  int ACC_LEN = 8,
  localparam int RW      = 2*WIDTH + 1 + $clog2(ACC_LEN)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [1:0]         mode,
  input  logic [2*WIDTH-1:0] operand1,
  input  logic [2*WIDTH-1:0] operand2,
  output logic               out_valid,
  output logic [2*RW-1:0]    result
);
  localparam int PW = 2*WIDTH;
  localparam int SW = PW + 1;
  localparam int CW = $clog2(ACC_LEN);

  typedef logic signed [WIDTH-1:0] comp_t;
  typedef logic signed [PW-1:0]    prod_t;
  typedef logic signed [SW-1:0]    sum_t;
  typedef logic signed [RW-1:0]    res_t;

  logic          s1_valid;
  logic [1:0]    s1_mode;
  comp_t         s1_ar, s1_ai, s1_br, s1_bi;
  logic          s2_valid;
  logic [1:0]    s2_mode;
  prod_t         s2_rr, s2_ii, s2_ri, s2_ir;
  logic          s3_valid, s3_acc;
  sum_t          s3_re, s3_im;
  logic [CW-1:0] cnt;
  res_t          acc_re, acc_im;
  res_t          ext_re, ext_im, sum_re, sum_im;
  logic          last;

  // NOTE: every output of a combinational block is assigned on every pass, so no latch can form.
  always_comb begin
    ext_re = res_t'(s3_re);
    ext_im = res_t'(s3_im);
    sum_re = (cnt == '0) ? ext_re : acc_re + ext_re;
    sum_im = (cnt == '0) ? ext_im : acc_im + ext_im;
    last   = (cnt == CW'(ACC_LEN - 1));
  end

  // NOTE: state is updated with non-blocking assignments so every stage sees the previous cycle's values.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      s1_valid  <= 1'b0;
      s1_mode   <= '0;
      s1_ar     <= '0;
      s1_ai     <= '0;
      s1_br     <= '0;
      s1_bi     <= '0;
      s2_valid  <= 1'b0;
      s2_mode   <= '0;
      s2_rr     <= '0;
      s2_ii     <= '0;
      s2_ri     <= '0;
      s2_ir     <= '0;
      s3_valid  <= 1'b0;
      s3_acc    <= 1'b0;
      s3_re     <= '0;
      s3_im     <= '0;
      cnt       <= '0;
      acc_re    <= '0;
      acc_im    <= '0;
      out_valid <= 1'b0;
      result    <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_mode <= mode;
        s1_ar   <= comp_t'(operand1[2*WIDTH-1:WIDTH]);
        s1_ai   <= comp_t'(operand1[WIDTH-1:0]);
        s1_br   <= comp_t'(operand2[2*WIDTH-1:WIDTH]);
        s1_bi   <= comp_t'(operand2[WIDTH-1:0]);
      end

      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_mode <= s1_mode;
        s2_rr   <= prod_t'(s1_ar) * prod_t'(s1_br);
        s2_ii   <= prod_t'(s1_ai) * prod_t'(s1_bi);
        s2_ri   <= prod_t'(s1_ar) * prod_t'(s1_bi);
        s2_ir   <= prod_t'(s1_ai) * prod_t'(s1_br);
      end

      s3_valid <= s2_valid;
      if (s2_valid) begin
        s3_acc <= s2_mode[1];
        if (s2_mode[0]) begin
          s3_re <= sum_t'(s2_rr) + sum_t'(s2_ii);
          s3_im <= sum_t'(s2_ir) - sum_t'(s2_ri);
        end else begin
          s3_re <= sum_t'(s2_rr) - sum_t'(s2_ii);
          s3_im <= sum_t'(s2_ri) + sum_t'(s2_ir);
        end
      end

      out_valid <= 1'b0;
      if (s3_valid) begin
        if (s3_acc) begin
          acc_re <= sum_re;
          acc_im <= sum_im;
          if (last) begin
            result    <= {sum_re, sum_im};
            out_valid <= 1'b1;
            cnt       <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end else begin
          // A plain product closes any open group and discards its partial sum.
          result    <= {ext_re, ext_im};
          out_valid <= 1'b1;
          cnt       <= '0;
          acc_re    <= '0;
          acc_im    <= '0;
        end
      end
    end
  end
endmodule

// File: tb/tb_complex_mac_pipe.sv
// Self-checking bench for complex_mac_pipe: directed test-plan cases plus random
// traffic compared against a wide-integer complex arithmetic reference model.
module tb_complex_mac_pipe;
  localparam int WIDTH   = 32;
  localparam int ACC_LEN = 8;
  localparam int RW      = 2*WIDTH + 1 + $clog2(ACC_LEN);

  typedef logic signed [RW-1:0] wide_t;
  typedef struct packed {
    int              cyc;
    logic [2*RW-1:0] res;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               in_valid;
  logic [1:0]         mode;
  logic [2*WIDTH-1:0] operand1, operand2;
  logic               out_valid;
  logic [2*RW-1:0]    result;

  int    cyc = 0;
  int    checks = 0;
  int    errors = 0;
  ent_t  exp_q[$];
  ent_t  obs_q[$];
  wide_t grp_re, grp_im;
  int    grp_n;
  wide_t two63;

  complex_mac_pipe #(.WIDTH(WIDTH), .ACC_LEN(ACC_LEN)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .mode(mode),
    .operand1(operand1), .operand2(operand2),
    .out_valid(out_valid), .result(result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ent_t e;
    if (out_valid === 1'b1) begin
      e.cyc = cyc;
      e.res = result;
      obs_q.push_back(e);
    end
  end

  function automatic logic [2*WIDTH-1:0] cpx(input int re, input int im);
    return {WIDTH'(re), WIDTH'(im)};
  endfunction

  function automatic logic [2*RW-1:0] pack(input wide_t re, input wide_t im);
    return {re, im};
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one valid sample at a negedge and updates the reference model:
  // multiply modes emit their product; accumulate modes emit the group sum on the last sample.
  task automatic send(input logic [1:0] m, input logic [2*WIDTH-1:0] a, input logic [2*WIDTH-1:0] b);
    wide_t ar, ai, br, bi, pr, pi;
    ent_t  e;
    ar = wide_t'($signed(a[2*WIDTH-1:WIDTH]));
    ai = wide_t'($signed(a[WIDTH-1:0]));
    br = wide_t'($signed(b[2*WIDTH-1:WIDTH]));
    bi = wide_t'($signed(b[WIDTH-1:0]));
    if (m[0]) begin
      pr = ar*br + ai*bi;
      pi = ai*br - ar*bi;
    end else begin
      pr = ar*br - ai*bi;
      pi = ar*bi + ai*br;
    end
    e.cyc = cyc + 4;
    if (m[1]) begin
      grp_re += pr;
      grp_im += pi;
      grp_n++;
      if (grp_n == ACC_LEN) begin
        e.res = pack(grp_re, grp_im);
        exp_q.push_back(e);
        grp_n = 0; grp_re = '0; grp_im = '0;
      end
    end else begin
      grp_n = 0; grp_re = '0; grp_im = '0;
      e.res = pack(pr, pi);
      exp_q.push_back(e);
    end
    in_valid = 1'b1; mode = m; operand1 = a; operand2 = b;
    @(negedge clk);
    in_valid = 1'b0;
    mode     = 2'($urandom);
    operand1 = {$urandom, $urandom};
    operand2 = {$urandom, $urandom};
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 1'b0; mode = '0; operand1 = '0; operand2 = '0;
    grp_n = 0; grp_re = '0; grp_im = '0;
    idle(2);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL reset_result: got %h, expected 0", result); end
    rst_n = 1'b0;
  endtask

  task automatic test_multiply();
    exp_q.delete(); obs_q.delete();
    send(2'b00, cpx(3, 4), cpx(1, 2));
    idle(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL mul_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL mul[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
    checks++;
    if (obs_q.size() < 1 || obs_q[0].res !== pack(-5, 10)) begin errors++; $display("FAIL mul_value: got %0d outputs, expected re -5 im 10", obs_q.size()); end
    checks++;
    if (out_valid !== 1'b0 || result !== pack(-5, 10)) begin errors++; $display("FAIL mul_hold: got valid %b result %h, expected valid 0 result %h", out_valid, result, pack(-5, 10)); end
  endtask

  task automatic test_conj_back_to_back();
    exp_q.delete(); obs_q.delete();
    send(2'b01, cpx(3, 4), cpx(1, 2));
    for (int i = 0; i < 4; i++) begin
      send(2'b00, {$urandom, $urandom}, {$urandom, $urandom});
      send(2'b01, {$urandom, $urandom}, {$urandom, $urandom});
    end
    idle(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
    checks++;
    if (obs_q.size() < 1 || obs_q[0].res !== pack(11, -2)) begin errors++; $display("FAIL conj_value: got %0d outputs, expected re 11 im -2", obs_q.size()); end
  endtask

  task automatic test_corners();
    exp_q.delete(); obs_q.delete();
    send(2'b00, {32'h8000_0000, 32'h8000_0000}, {32'h8000_0000, 32'h8000_0000});
    send(2'b01, {32'h8000_0000, 32'h8000_0000}, {32'h8000_0000, 32'h8000_0000});
    idle(6);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL corner_count: got %0d outputs, expected 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL corner[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
    if (obs_q.size() == 2) begin
      checks++;
      if (obs_q[0].res !== pack(0, two63)) begin errors++; $display("FAIL corner_mul: got %h, expected %h", obs_q[0].res, pack(0, two63)); end
      checks++;
      if (obs_q[1].res !== pack(two63, 0)) begin errors++; $display("FAIL corner_conj: got %h, expected %h", obs_q[1].res, pack(two63, 0)); end
    end
  endtask

  task automatic test_accumulate();
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < ACC_LEN; i++) begin
      send(2'b10, cpx(1, 1), cpx(1, 1));
      if (i < ACC_LEN - 1) idle($urandom_range(0, 3));
    end
    for (int i = 0; i < ACC_LEN; i++) send(2'b11, cpx(2, 0), cpx(0, 1));
    idle(6);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL acc_count: got %0d outputs, expected 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL acc[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
    if (obs_q.size() == 2) begin
      checks++;
      if (obs_q[0].res !== pack(0, 16)) begin errors++; $display("FAIL acc_sum: got %h, expected re 0 im 16", obs_q[0].res); end
      checks++;
      if (obs_q[1].res !== pack(0, -16)) begin errors++; $display("FAIL acc_conj_sum: got %h, expected re 0 im -16", obs_q[1].res); end
    end
  endtask

  task automatic test_abort();
    exp_q.delete(); obs_q.delete();
    repeat (3) send(2'b10, cpx(5, -7), cpx(3, 2));
    send(2'b00, cpx(2, 0), cpx(3, 0));
    repeat (ACC_LEN) send(2'b10, cpx(1, 0), cpx(1, 0));
    idle(6);
    checks++;
    if (obs_q.size() != 2) begin errors++; $display("FAIL abort_count: got %0d outputs, expected 2", obs_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
    if (obs_q.size() == 2) begin
      checks++;
      if (obs_q[0].res !== pack(6, 0)) begin errors++; $display("FAIL abort_product: got %h, expected re 6 im 0", obs_q[0].res); end
      checks++;
      if (obs_q[1].res !== pack(8, 0)) begin errors++; $display("FAIL abort_fresh_sum: got %h, expected re 8 im 0", obs_q[1].res); end
    end
  endtask

  task automatic test_reset_mid();
    exp_q.delete(); obs_q.delete();
    repeat (5) send(2'b10, cpx(1, 0), cpx(1, 0));
    idle(4);
    repeat (3) send(2'b00, cpx(7, 1), cpx(2, 3));
    #2 rst_n = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL midreset_valid: got %b, expected 0", out_valid); end
    checks++;
    if (result !== '0) begin errors++; $display("FAIL midreset_result: got %h, expected 0", result); end
    exp_q.delete();
    grp_n = 0; grp_re = '0; grp_im = '0;
    @(negedge clk);
    rst_n = 1'b0;
    idle(8);
    checks++;
    if (obs_q.size() != 0) begin errors++; $display("FAIL midreset_flush: got %0d outputs, expected 0", obs_q.size()); end
    repeat (ACC_LEN) send(2'b10, cpx(1, 0), cpx(1, 0));
    idle(6);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin errors++; $display("FAIL midreset_group: got %0d outputs, expected 1 at cyc %0d", obs_q.size(), exp_q[0].cyc); end
    checks++;
    if (obs_q.size() < 1 || obs_q[0].res !== pack(8, 0)) begin errors++; $display("FAIL midreset_sum: got %0d outputs, expected re 8 im 0", obs_q.size()); end
  endtask

  task automatic test_random();
    logic [1:0] m;
    exp_q.delete(); obs_q.delete();
    for (int i = 0; i < 400; i++) begin
      m[1] = ($urandom_range(0, 9) != 0);
      m[0] = 1'($urandom);
      send(m, {$urandom, $urandom}, {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    idle(6);
    checks++;
    if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size()); end
    foreach (exp_q[i]) if (i < obs_q.size()) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand[%0d]: got cyc %0d re %0d im %0d, expected cyc %0d re %0d im %0d", i, obs_q[i].cyc, $signed(obs_q[i].res[2*RW-1:RW]), $signed(obs_q[i].res[RW-1:0]), exp_q[i].cyc, $signed(exp_q[i].res[2*RW-1:RW]), $signed(exp_q[i].res[RW-1:0])); end
    end
  endtask

  initial begin
    two63 = wide_t'(1) <<< 63;
    test_reset();
    test_multiply();
    test_conj_back_to_back();
    test_corners();
    test_accumulate();
    test_abort();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/complex_mac_pipe.md
# complex_mac_pipe

Pipelined, parametrised complex multiply-accumulate unit: the clocked, width-generic successor to the combinational complex multiplier. Each valid cycle accepts two signed complex operands and produces either a full-precision product, the product with the second operand conjugated, or a running sum of such products over a fixed-length group (dot-product mode). It sits in the datapath wherever streaming complex samples need multiplying or correlating at one sample per cycle.

## Interface
- WIDTH, 32, bits per real/imag component of each operand (signed two's complement)
- ACC_LEN, 8, products summed per output in accumulate modes (power of two, >= 2)
- Derived: RW = 2*WIDTH + 1 + $clog2(ACC_LEN), bits per result component (68 at defaults)

- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous reset, active-high (asserted = 1); clears all state immediately
- in_valid  in  1  operand/mode qualifier
- mode  in  2  00 multiply, 01 conj multiply (op1*conj(op2)), 10 accumulate multiply, 11 accumulate conj
- operand1  in  2*WIDTH  [2W-1:W] real, [W-1:0] imag
- operand2  in  2*WIDTH  same packing
- out_valid  out  1  one-cycle pulse, result valid
- result  out  2*RW  [2RW-1:RW] real, [RW-1:0] imag, signed

## Operation
- Multiply: re = ar*br - ai*bi, im = ar*bi + ai*br. Conj: re = ar*br + ai*bi, im = ai*br - ar*bi.
- Full precision: products 2W bits, sum 2W+1 bits, sign-extended to RW; no rounding, saturation or overflow possible at any legal input, including all -2^(W-1) corners.
- Pipeline: S1 registers operands+mode; S2 registers four partial products; S3 registers add/sub result; S4 registers output/accumulator.
- mode[0] selects conjugation per sample; mode[1] selects accumulate per sample.
- Accumulate: counter cnt (0..ACC_LEN-1) counts accumulate samples leaving S3. First sample of a group loads acc, later ones add. On the ACC_LEN-th sample, result = final sum, out_valid = 1, cnt -> 0. No output for intermediate samples.
- Gaps in in_valid are allowed anywhere; only valid samples count. Conj and non-conj samples may mix within one group.
- Abort: a non-accumulate sample reaching S4 while cnt != 0 discards the open group (cnt -> 0, partial sum dropped) and is output normally as its own product.
- result holds its last value between out_valid pulses.

## Timing
- Reset (async assert): out_valid = 0, result = 0, cnt = 0, all stage valid bits = 0, acc = 0. Reset mid-operation drops every in-flight sample; nothing emerges after release from pre-reset inputs.
- Throughput: one sample per cycle, no backpressure, no stall.
- Latency: sample sampled at edge t (in_valid = 1) -> out_valid high in cycle following edge t+3 (3 cycles) in multiply modes; in accumulate, 3 cycles after the ACC_LEN-th sample.
- Back-to-back multiply samples give back-to-back out_valid pulses in the same order.
- Inputs sampled only when in_valid = 1; operand/mode values otherwise ignored.
- First valid sample accepted on the first edge after rst_n deasserts.

## Test plan
- mode 00, op1 = 3+4j, op2 = 1+2j -> out_valid 3 cycles later, re = -5, im = 10, single pulse.
- mode 01, same operands -> re = 11, im = -2; then back-to-back 00/01 pairs -> alternating outputs on consecutive cycles.
- mode 00 and 01 with both operands = -2^31 - 2^31j -> mode 00: re = 0, im = 2^63; mode 01: re = 2^63, im = 0 (sign-extended, no wrap).
- mode 10, eight samples (1+1j)*(1+1j) with random 0-3 cycle gaps -> exactly one out_valid, 3 cycles after 8th sample, re = 0, im = 16; immediately following group of eight mode-11 (2+0j)*(0+1j) samples -> re = 0, im = -16.
- Abort: three mode-10 samples, then one mode-00 (2+0j)*(3+0j) -> single output re = 6, im = 0; next eight mode-10 (1+0j)*(1+0j) -> re = 8 (no stale partial sum).
- Assert rst_n for one cycle with three samples in flight and cnt = 5 -> out_valid, result drop to 0 without waiting for an edge; no output after release until new inputs; a fresh 8-sample group then sums correctly.
